// File: rtl/pipe_stage_latch_if.sv
// Stage-boundary bundle between two pipeline stages; slave = the latch, master = its environment.
// Counter signals exist only when PIPE_STAGE_LATCH_STALL_CNT_EN is defined.
interface pipe_stage_latch_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 2
);
  logic                   enable;
  logic                   flush;
  logic                   valid_in;
  logic [WIDTH-1:0]       pc_in;
  logic [NCH*WIDTH-1:0]   data_in;
  logic [WIDTH-1:0]       ir_in;
  logic [WIDTH-1:0]       pc_out;
  logic [NCH*WIDTH-1:0]   data_out;
  logic [WIDTH-1:0]       ir_out;
  logic                   valid_out;
`ifdef PIPE_STAGE_LATCH_STALL_CNT_EN
  logic                   cnt_clr;
  logic [15:0]            stall_cnt;

  modport master (
    output enable, flush, valid_in, pc_in, data_in, ir_in, cnt_clr,
    input  pc_out, data_out, ir_out, valid_out, stall_cnt
  );

  modport slave (
    input  enable, flush, valid_in, pc_in, data_in, ir_in, cnt_clr,
    output pc_out, data_out, ir_out, valid_out, stall_cnt
  );
`else
  modport master (
    output enable, flush, valid_in, pc_in, data_in, ir_in,
    input  pc_out, data_out, ir_out, valid_out
  );

  modport slave (
    input  enable, flush, valid_in, pc_in, data_in, ir_in,
    output pc_out, data_out, ir_out, valid_out
  );
`endif
endinterface

// File: rtl/pipe_stage_latch.sv
// Configurable pipeline stage latch (PC, NCH data channels, IR, valid); optional stall counter via PIPE_STAGE_LATCH_STALL_CNT_EN.
// One-edge latency on every field; enable=0 stalls, flush injects a NOP bubble; all outputs are registered.
module pipe_stage_latch #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      NCH     = 2,
  parameter logic [WIDTH-1:0] NOP     = '0,
  parameter bit               IR_FREE = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  pipe_stage_latch_if.slave  bus
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] ir_q;
  logic             valid_q;
  logic             ir_load;

  // PC/data never see flush: they follow enable only and are qualified downstream by valid_out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else if (bus.enable) begin
      pc_q <= bus.pc_in;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [WIDTH-1:0] ch_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        ch_q <= '0;
      end else if (bus.enable) begin
        ch_q <= bus.data_in[k*WIDTH +: WIDTH];
      end
    end

    assign bus.data_out[k*WIDTH +: WIDTH] = ch_q;
  end

  assign ir_load = IR_FREE ? 1'b1 : bus.enable;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q    <= NOP;
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      ir_q    <= NOP;
      valid_q <= 1'b0;
    end else if (ir_load) begin
      ir_q    <= bus.ir_in;
      valid_q <= bus.valid_in;
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.ir_out    = ir_q;
  assign bus.valid_out = valid_q;

`ifdef PIPE_STAGE_LATCH_STALL_CNT_EN
  logic [15:0] cnt_q;
  logic        cnt_inc;

  // Counts only edges that hold a real instruction; saturates instead of wrapping.
  assign cnt_inc = !bus.enable && !bus.flush && valid_q && (cnt_q != 16'hFFFF);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench for pipe_stage_latch: default, IR_FREE=1 and NCH=4/WIDTH=16 instances.
module tb_pipe_stage_latch;

  localparam logic [31:0] NOP_A = 32'h0000_0013;
  localparam logic [31:0] NOP_F = 32'hFFFF_FFFF;
  localparam logic [15:0] NOP_W = 16'h00AA;

  typedef struct {
    logic        en;
    logic        fl;
    logic        vin;
    logic [31:0] pc;
    logic [63:0] dat;
    logic [31:0] ir;
    logic [31:0] e_pc;
    logic [63:0] e_dat;
    logic [31:0] e_ir;
    logic        e_v;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  vec_t        vecs_a[10];
  vec_t        vecs_f[6];
  logic [15:0] pat[3][4];

  always #5 clock = ~clock;

  pipe_stage_latch_if #(.WIDTH(32), .NCH(2)) bus_a ();
  pipe_stage_latch_if #(.WIDTH(32), .NCH(2)) bus_f ();
  pipe_stage_latch_if #(.WIDTH(16), .NCH(4)) bus_w ();

  pipe_stage_latch #(.WIDTH(32), .NCH(2), .NOP(NOP_A), .IR_FREE(1'b0)) u_a (
    .clock(clock), .reset(reset), .bus(bus_a));
  pipe_stage_latch #(.WIDTH(32), .NCH(2), .NOP(NOP_F), .IR_FREE(1'b1)) u_f (
    .clock(clock), .reset(reset), .bus(bus_f));
  pipe_stage_latch #(.WIDTH(16), .NCH(4), .NOP(NOP_W), .IR_FREE(1'b0)) u_w (
    .clock(clock), .reset(reset), .bus(bus_w));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [31:0] pc, input logic [63:0] dat,
                         input logic [31:0] ir, input logic v);
    check($sformatf("%s.pc", tag),    64'(bus_a.pc_out),    64'(pc));
    check($sformatf("%s.data", tag),  bus_a.data_out,       dat);
    check($sformatf("%s.ir", tag),    64'(bus_a.ir_out),    64'(ir));
    check($sformatf("%s.valid", tag), 64'(bus_a.valid_out), 64'(v));
  endtask

  task automatic check_f(input string tag, input logic [31:0] pc, input logic [63:0] dat,
                         input logic [31:0] ir, input logic v);
    check($sformatf("%s.pc", tag),    64'(bus_f.pc_out),    64'(pc));
    check($sformatf("%s.data", tag),  bus_f.data_out,       dat);
    check($sformatf("%s.ir", tag),    64'(bus_f.ir_out),    64'(ir));
    check($sformatf("%s.valid", tag), 64'(bus_f.valid_out), 64'(v));
  endtask

  task automatic set_a(input logic en, input logic fl, input logic vin, input logic [31:0] pc,
                       input logic [63:0] dat, input logic [31:0] ir);
    bus_a.enable = en; bus_a.flush = fl; bus_a.valid_in = vin;
    bus_a.pc_in = pc; bus_a.data_in = dat; bus_a.ir_in = ir;
  endtask

  task automatic rand_a();
    set_a(1'($urandom), 1'($urandom), 1'($urandom), $urandom, {$urandom, $urandom}, $urandom);
  endtask

  task automatic set_w(input logic en, input logic fl, input int p, input logic [15:0] ir);
    bus_w.enable = en; bus_w.flush = fl; bus_w.valid_in = 1'b1;
    bus_w.pc_in = 16'h0100 + 16'(p); bus_w.ir_in = ir;
    bus_w.data_in = {pat[p][3], pat[p][2], pat[p][1], pat[p][0]};
  endtask

  task automatic check_w(input string tag, input int p, input logic [15:0] ir, input logic v);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s.ch%0d", tag, k), 64'(bus_w.data_out[k*16 +: 16]), 64'(pat[p][k]));
    check($sformatf("%s.ir", tag),    64'(bus_w.ir_out),    64'(ir));
    check($sformatf("%s.valid", tag), 64'(bus_w.valid_out), 64'(v));
  endtask

  initial begin
    // en fl vin pc dat ir | exp pc dat ir valid
    vecs_a[0] = '{1'b1, 1'b0, 1'b1, 32'h40, {32'hBEEF, 32'h1234}, 32'h0842_0005,
                  32'h40, {32'hBEEF, 32'h1234}, 32'h0842_0005, 1'b1};
    vecs_a[1] = '{1'b0, 1'b0, 1'b0, 32'h44, {32'h1, 32'h2}, 32'h111,
                  32'h40, {32'hBEEF, 32'h1234}, 32'h0842_0005, 1'b1};
    vecs_a[2] = '{1'b0, 1'b0, 1'b1, 32'h48, {32'h3, 32'h4}, 32'h222,
                  32'h40, {32'hBEEF, 32'h1234}, 32'h0842_0005, 1'b1};
    vecs_a[3] = '{1'b0, 1'b0, 1'b0, 32'h4C, {32'h5, 32'h6}, 32'h333,
                  32'h40, {32'hBEEF, 32'h1234}, 32'h0842_0005, 1'b1};
    vecs_a[4] = '{1'b0, 1'b1, 1'b1, 32'h50, {32'h7, 32'h8}, 32'h444,
                  32'h40, {32'hBEEF, 32'h1234}, NOP_A, 1'b0};
    vecs_a[5] = '{1'b0, 1'b1, 1'b1, 32'h54, {32'h7, 32'h8}, 32'h444,
                  32'h40, {32'hBEEF, 32'h1234}, NOP_A, 1'b0};
    vecs_a[6] = '{1'b1, 1'b1, 1'b1, 32'h58, {32'h9, 32'hA}, 32'h555,
                  32'h58, {32'h9, 32'hA}, NOP_A, 1'b0};
    vecs_a[7] = '{1'b1, 1'b0, 1'b0, 32'h5C, {32'hB, 32'hC}, 32'h666,
                  32'h5C, {32'hB, 32'hC}, 32'h666, 1'b0};
    vecs_a[8] = '{1'b1, 1'b0, 1'b1, 32'h60, {32'hDEAD_BEEF, 32'hCAFE_F00D}, 32'h777,
                  32'h60, {32'hDEAD_BEEF, 32'hCAFE_F00D}, 32'h777, 1'b1};
    vecs_a[9] = '{1'b0, 1'b0, 1'b0, 32'h64, {32'h0, 32'h0}, 32'h888,
                  32'h60, {32'hDEAD_BEEF, 32'hCAFE_F00D}, 32'h777, 1'b1};

    vecs_f[0] = '{1'b1, 1'b0, 1'b1, 32'h100, {32'hAA, 32'hBB}, 32'h9,
                  32'h100, {32'hAA, 32'hBB}, 32'h9, 1'b1};
    vecs_f[1] = '{1'b0, 1'b0, 1'b0, 32'h104, {32'h1, 32'h1}, 32'h1,
                  32'h100, {32'hAA, 32'hBB}, 32'h1, 1'b0};
    vecs_f[2] = '{1'b0, 1'b0, 1'b1, 32'h108, {32'h2, 32'h2}, 32'h2,
                  32'h100, {32'hAA, 32'hBB}, 32'h2, 1'b1};
    vecs_f[3] = '{1'b0, 1'b0, 1'b1, 32'h10C, {32'h3, 32'h3}, 32'h3,
                  32'h100, {32'hAA, 32'hBB}, 32'h3, 1'b1};
    vecs_f[4] = '{1'b0, 1'b1, 1'b1, 32'h110, {32'h4, 32'h4}, 32'h4,
                  32'h100, {32'hAA, 32'hBB}, NOP_F, 1'b0};
    vecs_f[5] = '{1'b0, 1'b0, 1'b1, 32'h114, {32'h5, 32'h5}, 32'h5,
                  32'h100, {32'hAA, 32'hBB}, 32'h5, 1'b1};

    pat[0] = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};
    pat[1] = '{16'h0001, 16'h0002, 16'h0004, 16'h8000};
    pat[2] = '{16'h5A5A, 16'hFFFF, 16'h0000, 16'h1234};

    set_a(1'b0, 1'b0, 1'b0, '0, '0, '0);
    bus_f.enable = 1'b0; bus_f.flush = 1'b0; bus_f.valid_in = 1'b0;
    bus_f.pc_in = '0; bus_f.data_in = '0; bus_f.ir_in = '0;
    set_w(1'b0, 1'b0, 0, 16'h0);
`ifdef PIPE_STAGE_LATCH_STALL_CNT_EN
    bus_a.cnt_clr = 1'b0; bus_f.cnt_clr = 1'b0; bus_w.cnt_clr = 1'b0;
`endif

    // Reset held low with toggling inputs: outputs pinned both between and just after edges.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      rand_a();
      #2 check_a($sformatf("rst_mid%0d", i), 32'h0, 64'h0, NOP_A, 1'b0);
      @(posedge clock);
      #1 check_a($sformatf("rst_edge%0d", i), 32'h0, 64'h0, NOP_A, 1'b0);
    end
    check("rst_w.ir", 64'(bus_w.ir_out), 64'(NOP_W));
    check("rst_f.ir", 64'(bus_f.ir_out), 64'(NOP_F));

    @(negedge clock);
    set_a(1'b0, 1'b0, 1'b0, '0, '0, '0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      set_a(vecs_a[i].en, vecs_a[i].fl, vecs_a[i].vin, vecs_a[i].pc, vecs_a[i].dat, vecs_a[i].ir);
      @(posedge clock);
      #1 check_a($sformatf("vec_a%0d", i), vecs_a[i].e_pc, vecs_a[i].e_dat, vecs_a[i].e_ir, vecs_a[i].e_v);
    end

    // Asynchronous reset in the middle of a stall, then a normal first edge.
    @(negedge clock);
    set_a(1'b0, 1'b0, 1'b1, 32'h68, {32'h11, 32'h22}, 32'h999);
    #2 reset = 1'b0;
    #1 check_a("rst_async", 32'h0, 64'h0, NOP_A, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    set_a(1'b1, 1'b0, 1'b1, 32'h70, {32'h33, 32'h44}, 32'hABC);
    @(posedge clock);
    #1 check_a("rst_release", 32'h70, {32'h33, 32'h44}, 32'hABC, 1'b1);
    set_a(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 32'h0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      bus_f.enable = vecs_f[i].en; bus_f.flush = vecs_f[i].fl; bus_f.valid_in = vecs_f[i].vin;
      bus_f.pc_in = vecs_f[i].pc; bus_f.data_in = vecs_f[i].dat; bus_f.ir_in = vecs_f[i].ir;
      @(posedge clock);
      #1 check_f($sformatf("vec_f%0d", i), vecs_f[i].e_pc, vecs_f[i].e_dat, vecs_f[i].e_ir, vecs_f[i].e_v);
    end

    // Wide instance: per-channel slices, stall hold, flush with enable.
    @(negedge clock); set_w(1'b1, 1'b0, 0, 16'h0101);
    @(posedge clock); #1 check_w("w_p0", 0, 16'h0101, 1'b1);
    @(negedge clock); set_w(1'b1, 1'b0, 1, 16'h0202);
    @(posedge clock); #1 check_w("w_p1", 1, 16'h0202, 1'b1);
    check("w_p1.pc", 64'(bus_w.pc_out), 64'h0101);
    @(negedge clock); set_w(1'b0, 1'b0, 2, 16'h0303);
    @(posedge clock); #1 check_w("w_hold", 1, 16'h0202, 1'b1);
    @(negedge clock); set_w(1'b1, 1'b1, 2, 16'h0404);
    @(posedge clock); #1 check_w("w_flush", 2, NOP_W, 1'b0);

`ifdef PIPE_STAGE_LATCH_STALL_CNT_EN
    @(negedge clock);
    reset = 1'b0;
    #1 check("cnt_rst", 64'(bus_a.stall_cnt), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    set_a(1'b0, 1'b0, 1'b1, 32'h80, 64'h0, 32'h1);
    repeat (2) @(negedge clock);
    check("cnt_invalid_hold", 64'(bus_a.stall_cnt), 64'h0);
    bus_a.enable = 1'b1;
    @(negedge clock);
    bus_a.enable = 1'b0;
    check("cnt_load", 64'(bus_a.stall_cnt), 64'h0);
    repeat (5) @(negedge clock);
    check("cnt_five", 64'(bus_a.stall_cnt), 64'h5);
    bus_a.cnt_clr = 1'b1;
    @(negedge clock);
    bus_a.cnt_clr = 1'b0;
    check("cnt_clr", 64'(bus_a.stall_cnt), 64'h0);
    repeat (65540) @(negedge clock);
    check("cnt_sat", 64'(bus_a.stall_cnt), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_latch.md
# pipe_stage_latch

Parametrised inter-stage pipeline latch for the processor datapath, generalising the fixed four-register stage latch into a configurable stage boundary. It carries a PC, NCH generic data channels of WIDTH bits and an instruction word. It also tracks a per-stage valid bit and supports stall (hold), flush (bubble injection) and a free-running instruction path. One instance sits between each pair of pipeline stages (F/D, D/X, X/M, M/W).

## Interface
- WIDTH, 32 — bit width of PC, each data channel and IR
- NCH, 2 — number of generic data channels (1..8)
- NOP, 32'h0000_0000 — instruction word loaded on reset and on flush
- IR_FREE, 0 — 1: IR and valid load every cycle regardless of enable; 0: IR follows enable

Ports:
- clock  in  1 — rising-edge clock, sole clock domain
- reset  in  1 — asynchronous, active-low; asserted (0) forces all state to reset values immediately
- enable  in  1 — 1: load PC/data (and IR/valid when IR_FREE=0); 0: hold (stall)
- flush  in  1 — 1: inject bubble at next edge
- valid_in  in  1 — upstream stage holds a real instruction
- pc_in  in  WIDTH — program counter
- data_in  in  NCH*WIDTH — channel k occupies bits [k*WIDTH +: WIDTH]
- ir_in  in  WIDTH — instruction word
- pc_out  out  WIDTH — latched PC
- data_out  out  NCH*WIDTH — latched channels, same packing
- ir_out  out  WIDTH — latched instruction
- valid_out  out  1 — latched valid
- stall_cnt  out  16 — present only with PIPE_STAGE_LATCH_STALL_CNT_EN
- cnt_clr  in  1 — synchronous clear of stall_cnt; present only with the macro

## Operation
- Reset (reset=0, async): pc_out=0, data_out=0, ir_out=NOP, valid_out=0, stall_cnt=0.
- Priority at each rising edge: reset > flush > enable > hold.
- flush=1: ir_out<=NOP and valid_out<=0, independent of enable and IR_FREE. pc_out and data_out load if enable=1 and hold otherwise. Downstream must qualify them with valid_out.
- flush=0, enable=1: all outputs load their inputs; valid_out<=valid_in.
- flush=0, enable=0, IR_FREE=0: all outputs hold.
- flush=0, enable=0, IR_FREE=1: pc_out and data_out hold; ir_out<=ir_in and valid_out<=valid_in.
- Channels are independent registers with no arithmetic. Bit ordering is preserved exactly.
- No combinational path from any input to any output.

## Timing
- Latency: one clock edge from input to output for every field.
- Stall holds for as many cycles as enable=0, with no drift or decay.
- Simultaneous flush and enable=0: the bubble is still injected and PC/data hold.
- Flush while valid_out=0: no visible change beyond ir_out=NOP.
- Reset asserted mid-stall or mid-flush: outputs go to reset values without waiting for a clock edge. The first edge after deassertion behaves as a normal edge.
- Reset deassertion is assumed synchronised externally.

## Configuration
- PIPE_STAGE_LATCH_STALL_CNT_EN defined: adds stall_cnt and cnt_clr.
  - stall_cnt increments on every edge where enable=0, flush=0 and valid_out=1, i.e. a real instruction is held.
  - stall_cnt saturates at 16'hFFFF and never wraps.
  - cnt_clr=1 sets it to 0 at the next edge and takes priority over increment.
  - Reset clears it.
- Macro undefined: stall_cnt and cnt_clr ports and all counter logic are absent. Latch behaviour is otherwise identical.

## Test plan
- Reset: hold reset=0 with random inputs toggling -> pc_out=0, data_out=0, ir_out=NOP, valid_out=0 at all times, including between clock edges.
- Load/stall: enable=1, pc_in=32'h40, data_in={32'hBEEF,32'h1234}, ir_in=32'h0842_0005, valid_in=1 for one edge; then enable=0 for 3 edges with changed inputs -> outputs stay 32'h40/{BEEF,1234}/0842_0005/1 throughout.
- Flush with stall: valid latched instruction, then enable=0, flush=1 for one edge -> ir_out=NOP, valid_out=0, pc_out/data_out unchanged.
- IR_FREE=1 instance: enable=0, ir_in stepping 1,2,3 -> ir_out follows 1,2,3 one edge later while pc_out and data_out hold.
- Counter (macro defined): valid_out=1, enable=0 for 5 edges -> stall_cnt=5. cnt_clr=1 for one edge -> 0. Preload scenario driving 65540 stall edges -> stall_cnt=16'hFFFF.
- NCH=4, WIDTH=16 instance: distinct patterns per channel -> each channel appears in its own slice, with no cross-channel corruption.
